// File: rtl/fft_pkg.sv
// fft_pkg: shared constants, sample/frame types and read-side FSM states for the FFT front end
package fft_pkg;
   localparam int FFT_N = 8;
   localparam int FFT_DATA_WIDTH = 16;
   typedef struct packed {
      logic signed [FFT_DATA_WIDTH-1:0] re;
      logic signed [FFT_DATA_WIDTH-1:0] im;
   } cplx_t;
   typedef logic [FFT_N-1:0][FFT_DATA_WIDTH-1:0] frame_t;
   typedef enum logic {IDLE, ISSUE} rd_state_t;
endpackage

// File: rtl/fft_frame_buf.sv
// fft_frame_buf: N-entry complex register bank, indexed write port and parallel read port
module fft_frame_buf
   import fft_pkg::*;
#(
   parameter int DATA_WIDTH = FFT_DATA_WIDTH,
   parameter int N = FFT_N,
   localparam int IW = $clog2(N)
) (
   input  logic                            clk,
   input  logic                            we,
   input  logic [IW-1:0]                   idx,
   input  logic [DATA_WIDTH-1:0]           wr_real,
   input  logic [DATA_WIDTH-1:0]           wr_imag,
   output logic [N-1:0][DATA_WIDTH-1:0]    rd_real,
   output logic [N-1:0][DATA_WIDTH-1:0]    rd_imag
);
   // store one sample into the addressed slot; contents are qualified by the owner's full flag
   always_ff @(posedge clk)
      if (we) begin
         rd_real[idx] <= wr_real;
         rd_imag[idx] <= wr_imag;
      end
endmodule

// File: rtl/fft_8p_in_buf.sv
// fft_8p_in_buf: ping-pong frame assembler feeding the parallel FFT core (optional FFT_IN_PRESCALE_EN)
module fft_8p_in_buf
   import fft_pkg::*;
#(
   parameter int DATA_WIDTH = FFT_DATA_WIDTH,
   parameter int N = FFT_N
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            s_valid,
   output logic                            s_ready,
   input  logic [DATA_WIDTH-1:0]           s_real,
   input  logic [DATA_WIDTH-1:0]           s_imag,
   input  logic                            out_ready,
   output logic                            start,
   output logic [N-1:0][DATA_WIDTH-1:0]    x_real,
   output logic [N-1:0][DATA_WIDTH-1:0]    x_imag
);
   localparam int IW = $clog2(N);
   logic wr_buf, rd_buf, xfer, last, issue;
   logic [IW-1:0] wr_idx;
   logic [1:0] full, full_n;
   rd_state_t state, state_n;
   logic [DATA_WIDTH-1:0] wr_real, wr_imag;
   logic [1:0][N-1:0][DATA_WIDTH-1:0] bank_real, bank_imag;
   assign s_ready = !rst && !full[wr_buf];
   assign xfer = s_valid && s_ready;
   assign last = wr_idx == IW'(N - 1);
   assign issue = full[rd_buf] && out_ready;
`ifdef FFT_IN_PRESCALE_EN
   assign wr_real = $signed(s_real) >>> IW;
   assign wr_imag = $signed(s_imag) >>> IW;
`else
   assign wr_real = s_real;
   assign wr_imag = s_imag;
`endif
   for (genvar b = 0; b < 2; b++) begin : g_buf
      fft_frame_buf #(.DATA_WIDTH(DATA_WIDTH), .N(N)) u_buf (
         .clk     (clk),
         .we      (xfer && wr_buf == 1'(b)),
         .idx     (wr_idx),
         .wr_real (wr_real),
         .wr_imag (wr_imag),
         .rd_real (bank_real[b]),
         .rd_imag (bank_imag[b])
      );
   end
   // next full flags and read FSM; a drain and a fill never target the same buffer
   always_comb begin
      full_n = full;
      if (issue) full_n[rd_buf] = 1'b0;
      if (xfer && last) full_n[wr_buf] = 1'b1;
      state_n = issue ? ISSUE : IDLE;
      start = state == ISSUE;
   end
   // write pointer, read pointer, FSM state and output frame registers
   always_ff @(posedge clk)
      if (rst) begin
         state <= IDLE;
         full <= '0;
         wr_buf <= 1'b0;
         rd_buf <= 1'b0;
         wr_idx <= '0;
         x_real <= '0;
         x_imag <= '0;
      end else begin
         state <= state_n;
         full <= full_n;
         if (xfer) begin
            wr_idx <= wr_idx + 1'b1;
            if (last) wr_buf <= !wr_buf;
         end
         if (issue) begin
            rd_buf <= !rd_buf;
            x_real <= bank_real[rd_buf];
            x_imag <= bank_imag[rd_buf];
         end
      end
endmodule
